// File: rtl/cnt_chk_pkg.sv
// Purpose : shared types and helpers for the counter sequence checker.
// Latency : n/a (types, constants and a combinational helper only).
// Backpr. : n/a.
package cnt_chk_pkg;

    // Checker FSM: HUNT until enough consecutive good steps are seen, then LOCKED.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Run counter width; large enough for LOCK_CNT up to 15.
    localparam int RUN_W = 4;

    // Modulo +/-1 on a 32-bit container. The caller truncates to its own width,
    // which gives modulo 2^WIDTH wrap in both directions for free.
    function automatic logic [31:0] next_val(input logic [31:0] prev, input logic m);
        return m ? (prev - 32'd1) : (prev + 32'd1);
    endfunction

endpackage

// File: rtl/cnt_step_gen.sv
// Purpose : next expected count value from the previous sample and direction.
// Latency : purely combinational (0 cycles).
// Backpr. : none; output follows inputs continuously.
// Ports   : prev (WIDTH) previous sample, m direction (0 up, 1 down),
//           expected (WIDTH) prev+1 or prev-1 modulo 2^WIDTH.
module cnt_step_gen
    import cnt_chk_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] prev,
    input  logic             m,
    output logic [WIDTH-1:0] expected
);

    logic [31:0] prev_wide;
    logic [31:0] nxt_wide;
    logic        unused_hi;

    always_comb begin
        prev_wide              = '0;
        prev_wide[WIDTH-1:0]   = prev;
        nxt_wide               = next_val(prev_wide, m);
        expected               = nxt_wide[WIDTH-1:0];
    end

    // Upper bits of the wide result are intentionally dropped (modulo wrap).
    assign unused_hi = ^nxt_wide;

endmodule

// File: rtl/cnt_seq_checker.sv
// Purpose : validates a +/-1 counter bus; locks after LOCK_CNT good steps, flags/counts breaks while locked.
// Latency : locked/err/err_cnt visible the cycle after the sample edge; expected is combinational.
// Backpr. : none; pure observer, samples whenever en=1 and never stalls the producer.
// Ports   : clk, res (async active-low), en sample strobe, m direction (0 up/1 down),
//           cnt_in monitored value, expected next expected value, locked, err, err_cnt (saturating).
// Build   : define STICKY_ERR_EN to make err hold at 1 from the first break until reset;
//           otherwise err is a one-cycle pulse per break.
module cnt_seq_checker
    import cnt_chk_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             m,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] expected,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [RUN_W-1:0] LOCK_TGT = LOCK_CNT[RUN_W-1:0];

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic             have_prev;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nxt;
    logic             match;
    logic             brk;

    cnt_step_gen #(.WIDTH(WIDTH)) u_step (
        .prev     (prev),
        .m        (m),
        .expected (expected)
    );

    // A hold (cnt_in == prev) never equals prev+/-1 for WIDTH>=2, so it falls out as a mismatch.
    assign match   = (cnt_in == expected);
    assign run_nxt = run + RUN_W'(1);
    // A break only counts on a real comparison while locked.
    assign brk     = en & have_prev & (state == LOCKED) & ~match;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= HUNT;
            prev      <= '0;
            have_prev <= 1'b0;
            run       <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
`ifdef STICKY_ERR_EN
            err <= err | brk;
`else
            err <= brk;
`endif
            if (en) begin
                // Always resynchronise on the newest value, good or bad.
                prev <= cnt_in;
                if (!have_prev) begin
                    // First sample after reset is reference-only.
                    have_prev <= 1'b1;
                end else begin
                    case (state)
                        HUNT: begin
                            if (match) begin
                                if (run_nxt == LOCK_TGT) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                    run    <= '0;
                                end else begin
                                    run <= run_nxt;
                                end
                            end else begin
                                run <= '0;
                            end
                        end
                        LOCKED: begin
                            if (!match) begin
                                state  <= HUNT;
                                locked <= 1'b0;
                                run    <= '0;
                                if (err_cnt != '1) begin
                                    err_cnt <= err_cnt + ERR_W'(1);
                                end
                            end
                        end
                        default: begin
                            state  <= HUNT;
                            locked <= 1'b0;
                            run    <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/cnt_seq_checker.md
Name: cnt_seq_checker

Overview:
Monitor/checker on the receive side of a WIDTH-bit counter output bus; the counters are the producer and this block is the consumer that validates them.
- On each enabled sample, checks the value against the previous sample ±1 (direction set by m; m=0 up, same as the up/down counter convention).
- Locks after LOCK_CNT consecutive good steps.
- Flags and counts sequence breaks while locked.
- Used as an on-chip checker for counter blocks and in benches.

Parameters:
WIDTH, 3, width of monitored count bus
LOCK_CNT, 4, consecutive correct steps required to enter LOCKED (legal range 1..15)
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  clock; all state updates on rising edge
res  input  1  asynchronous active-low reset
en  input  1  sample strobe; cnt_in/m valid this cycle
m  input  1  direction of expected step: 0 = up (+1), 1 = down (-1)
cnt_in  input  WIDTH  monitored count value
expected  output  WIDTH  next expected value = prev+1 (m=0) or prev-1 (m=1), modulo 2^WIDTH; combinational from registered prev and live m
locked  output  1  registered; 1 while in LOCKED
err  output  1  registered; sequence-break indication
err_cnt  output  ERR_W  registered saturating count of sequence breaks

Behaviour:
- Reset (res=0, async): state=HUNT, prev=0, have_prev=0, run=0, locked=0, err=0, err_cnt=0; expected shows 1 (m=0) or 2^WIDTH-1 (m=1).
- Arithmetic: modulo 2^WIDTH wrap. Up: 2^WIDTH-1 -> 0. Down: 0 -> 2^WIDTH-1.
- match = (cnt_in == expected), evaluated only when en=1.
- A hold (cnt_in == prev) is a mismatch.
- en=0: no state, prev, run or err_cnt change; err is 0 the next cycle unless STICKY_ERR_EN applies.
- Every en=1 cycle loads prev <= cnt_in, including mismatches, so the checker resynchronises on the new value.
- First sample after reset (have_prev=0): prev loaded, have_prev<=1, no comparison, run stays 0.
- State HUNT:
  - en & match: run<=run+1.
  - When run+1 == LOCK_CNT: state<=LOCKED, run<=0.
  - en & !match: run<=0; no err.
- State LOCKED:
  - en & match: stay.
  - en & !match: err pulses 1 for one cycle; err_cnt<=err_cnt+1, saturating at 2^ERR_W-1; state<=HUNT; run<=0.
- Direction change: m is sampled with each sample. A valid direction reversal (e.g. 5 up, then 4 with m=1) is a match; no relock is needed.
- Latency: locked/err/err_cnt reflect a sample on the clock edge that captures it and are visible the following cycle.
- Reset mid-operation: everything returns to reset values immediately. The first post-reset sample is again reference-only.
- LOCK_CNT=1: a single good step locks.

Optional Feature:
STICKY_ERR_EN
- Defined: err is sticky. Once set it stays 1 until res asserts. err_cnt still increments per break.
- Undefined: err is a one-cycle pulse per break, as above.
- locked behaviour is identical in both builds.

Decomposition:
- Package cnt_chk_pkg: state enum {HUNT, LOCKED}; localparam for run counter width (4 bits); helper function next_val(prev, m) for modulo ±1.
- One sub-module, cnt_step_gen: purely combinational expected-value generator (prev, m -> expected). It is shared with the up/down counter bench models.
- The FSM, run counter and error counter live in the top module.

Test Plan:
- Reset, then en=1, m=0, feeding 0,1,2,3,4 -> locked=1 in the cycle after sample 4; err=0; err_cnt=0.
- Locked up-count through wrap 6,7,0,1 -> stays locked, no err (wrap legal); then m=1 feeding 0,7,6 -> stays locked (down wrap legal).
- Locked, inject 1,2,5 -> err=1 for exactly one cycle after sample 5; err_cnt=1; locked=0. Then 6,7,0,1 -> relocks.
- HUNT with 0,1,3 -> no err, run reset; then 4,5,6,7 needed before locked=1. Separately, hold 3,3 while locked -> err and err_cnt increment.
- ERR_W=2, five sequence breaks, each followed by relock -> err_cnt saturates at 3. With STICKY_ERR_EN, err stays 1 from the first break until res=0.
- Assert res low asynchronously mid-stream while locked with err_cnt=2 -> locked, err, err_cnt all 0 immediately. After release, the first sample produces no comparison.
